// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the asynchronous FIFO and its
// write-side arbitration logic.
package fifo_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int FIFO_DATASIZE = 8;
    localparam int ARB_NREQ      = 4;
    localparam int ARB_BURST     = 4;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// by searching from ptr upward, wrapping modulo NREQ.
module fifo_rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            found
);

    localparam int SW = PW + 1;

    logic [SW-1:0] idx;

    // The one-bit-wider sum keeps the wrap correct when NREQ is not a power of two.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + SW'(k);
            if (idx >= SW'(NREQ)) begin
                idx = idx - SW'(NREQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ producers,
// granting bounded bursts and gating writes combinationally on WFULL.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATASIZE = FIFO_DATASIZE,
    parameter int NREQ     = ARB_NREQ,
    parameter int BURST    = ARB_BURST
) (
    input  logic                     WCLK_I,
    input  logic                     WRST_N_I,
    input  logic [NREQ-1:0]          REQ_VALID_I,
    input  logic [NREQ*DATASIZE-1:0] REQ_DATA_I,
    output logic [NREQ-1:0]          REQ_READY_O,
    input  logic                     FIFO_WFULL_I,
    output logic                     FIFO_WINC_O,
    output logic [DATASIZE-1:0]      FIFO_WDATA_O,
    output logic [NREQ-1:0]          GRANT_O,
    output logic                     BUSY_O
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0]    ST_IDLE  = IDLE;
    localparam logic [0:0]    ST_XFER  = XFER;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

    logic [0:0]          state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [NREQ-1:0]     pick_gnt;
    logic                pick_found;
    logic                xfer;
    logic                own_valid;
    logic                do_write;
    logic [PW-1:0]       owner_idx;
    logic [DATASIZE-1:0] own_data;
    logic [DATASIZE-1:0] slice_masked [NREQ];

    fifo_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (REQ_VALID_I),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    assign xfer      = (state_q == ST_XFER);
    assign own_valid = |(REQ_VALID_I & grant_q);
    assign do_write  = xfer && own_valid && !FIFO_WFULL_I;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
        end
    end

    // AND-OR data mux; the one-hot grant makes at most one slice non-zero.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice_masked[gi] = grant_q[gi] ? REQ_DATA_I[gi*DATASIZE +: DATASIZE]
                                                  : '0;
        end
    endgenerate

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            own_data = own_data | slice_masked[i];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_XFER;
                    grant_d = pick_gnt;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                // A dropped valid releases even while the FIFO is full.
                if (!own_valid || (do_write && (cnt_q == CNT_LAST))) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (owner_idx == PTR_LAST) ? '0 : owner_idx + PW'(1);
                end else if (do_write) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge WCLK_I or negedge WRST_N_I) begin
        if (!WRST_N_I) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign REQ_READY_O  = (xfer && !FIFO_WFULL_I) ? grant_q : '0;
    assign FIFO_WINC_O  = do_write;
    assign FIFO_WDATA_O = xfer ? own_data : '0;
    assign GRANT_O      = grant_q;
    assign BUSY_O       = xfer;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: an expected-write queue per instance is
// filled by the stimulus and drained by negedge monitors watching FIFO_WINC_O.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  valid_a;
    logic [31:0] data_a;
    logic [3:0]  ready_a;
    logic        full_a;
    logic        winc_a;
    logic [7:0]  wdata_a;
    logic [3:0]  grant_a;
    logic        busy_a;

    logic [3:0]  valid_b;
    logic [31:0] data_b;
    logic [3:0]  ready_b;
    logic        full_b;
    logic        winc_b;
    logic [7:0]  wdata_b;
    logic [3:0]  grant_b;
    logic        busy_b;

    int          total = 0;
    int          bad   = 0;

    logic [7:0]  pdata [4];
    int          rem   [4];
    logic [11:0] exp_a [$];
    logic [11:0] exp_b [$];
    logic [11:0] e_a;
    logic [11:0] e_b;
    logic [9:0]  seq;

    localparam logic [31:0] B_SEQ = 32'b0001_0000_0010_0000_0001_0000_0010_0000;

    always #10 clk = ~clk;

    fifo_wr_arbiter #(.DATASIZE(8), .NREQ(4), .BURST(4)) dut_a (
        .WCLK_I       (clk),
        .WRST_N_I     (rst_n),
        .REQ_VALID_I  (valid_a),
        .REQ_DATA_I   (data_a),
        .REQ_READY_O  (ready_a),
        .FIFO_WFULL_I (full_a),
        .FIFO_WINC_O  (winc_a),
        .FIFO_WDATA_O (wdata_a),
        .GRANT_O      (grant_a),
        .BUSY_O       (busy_a)
    );

    fifo_wr_arbiter #(.DATASIZE(8), .NREQ(4), .BURST(1)) dut_b (
        .WCLK_I       (clk),
        .WRST_N_I     (rst_n),
        .REQ_VALID_I  (valid_b),
        .REQ_DATA_I   (data_b),
        .REQ_READY_O  (ready_b),
        .FIFO_WFULL_I (full_b),
        .FIFO_WINC_O  (winc_b),
        .FIFO_WDATA_O (wdata_b),
        .GRANT_O      (grant_b),
        .BUSY_O       (busy_b)
    );

    always_comb begin
        valid_a = '0;
        data_a  = '0;
        for (int i = 0; i < 4; i++) begin
            valid_a[i]      = (rem[i] != 0);
            data_a[i*8 +: 8] = pdata[i];
        end
    end

    always @(negedge clk) begin
        if (winc_a) begin
            total++;
            if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL sb_a: unexpected write grant=%b data=%h, none expected", grant_a, wdata_a);
            end else begin
                e_a = exp_a.pop_front();
                if ({grant_a, wdata_a} !== e_a) begin
                    bad++;
                    $display("FAIL sb_a: got grant=%b data=%h want grant=%b data=%h",
                             grant_a, wdata_a, e_a[11:8], e_a[7:0]);
                end else begin
                    $display("write a: grant=%b data=%h ok", grant_a, wdata_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (winc_b) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL sb_b: unexpected write grant=%b data=%h, none expected", grant_b, wdata_b);
            end else begin
                e_b = exp_b.pop_front();
                if ({grant_b, wdata_b} !== e_b) begin
                    bad++;
                    $display("FAIL sb_b: got grant=%b data=%h want grant=%b data=%h",
                             grant_b, wdata_b, e_b[11:8], e_b[7:0]);
                end else begin
                    $display("write b: grant=%b data=%h ok", grant_b, wdata_b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    // One clock: handshakes seen at the negedge advance the producers after the posedge.
    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        acc = valid_a & ready_a;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                pdata[i] = pdata[i] + 8'd1;
                rem[i]   = rem[i] - 1;
            end
        end
        #1;
    endtask

    task automatic set_prod(input int i, input logic [7:0] base, input int n);
        pdata[i] = base;
        rem[i]   = n;
    endtask

    task automatic push_a(input int i, input logic [7:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        exp_a.push_back({oh, d});
    endtask

    task automatic push_b(input int i, input logic [7:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        exp_b.push_back({oh, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        valid_b = '0;
        full_a  = 1'b0;
        full_b  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        full_a  = 1'b0;
        full_b  = 1'b0;
        valid_b = '0;
        data_b  = {8'h00, 8'h00, 8'hB1, 8'hA0};
        for (int i = 0; i < 4; i++) set_prod(i, 8'h00, 3);
        #3;
        chk("rst_grant", grant_a, 4'b0000);
        chk("rst_ready", ready_a, 4'b0000);
        chk("rst_winc",  winc_a,  1'b0);
        chk("rst_wdata", wdata_a, 8'h00);
        chk("rst_busy",  busy_a,  1'b0);
        chk("rst_grant_b", grant_b, 4'b0000);
        do_reset();

        // Single requester: bursts of four separated by one idle cycle.
        set_prod(1, 8'h10, 8);
        for (int n = 0; n < 8; n++) push_a(1, 8'h10 + 8'(n));
        #1;
        tick();
        chk("single_grant", grant_a, 4'b0010);
        for (int n = 0; n < 10; n++) begin
            seq[9-n] = winc_a;
            tick();
        end
        chk("single_winc_seq", seq, 10'b1111011110);
        chk("single_drained", exp_a.size(), 0);
        do_reset();

        // All four valid: order 0,1,2,3,0 with four words per grant.
        set_prod(0, 8'h00, 8);
        set_prod(1, 8'h20, 4);
        set_prod(2, 8'h40, 4);
        set_prod(3, 8'h60, 4);
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 4; n++) push_a(r, 8'(r * 32 + n));
        for (int n = 4; n < 8; n++) push_a(0, 8'(n));
        #1;
        tick();
        chk("rr_first_grant", grant_a, 4'b0001);
        repeat (25) tick();
        chk("rr_drained", exp_a.size(), 0);
        chk("rr_idle", busy_a, 1'b0);
        do_reset();

        // Reset mid-burst: outputs drop without a clock edge.
        for (int i = 0; i < 4; i++) set_prod(i, 8'(i * 32), 20);
        push_a(0, 8'h00);
        push_a(0, 8'h01);
        #1;
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant_a, 4'b0000);
        chk("midrst_ready", ready_a, 4'b0000);
        chk("midrst_winc",  winc_a,  1'b0);
        chk("midrst_busy",  busy_a,  1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        chk("midrst_regrant", grant_a, 4'b0001);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        #1;
        chk("midrst_drained", exp_a.size(), 0);
        do_reset();

        // Full stall after two words, then exactly two more before release.
        set_prod(0, 8'h00, 6);
        for (int n = 0; n < 4; n++) push_a(0, 8'(n));
        #1;
        tick();
        tick();
        tick();
        full_a = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_winc",  winc_a,  1'b0);
            chk("stall_ready", ready_a, 4'b0000);
            chk("stall_grant", grant_a, 4'b0001);
            tick();
        end
        full_a = 1'b0;
        #1;
        tick();
        tick();
        chk("stall_release_grant", grant_a, 4'b0000);
        chk("stall_release_busy",  busy_a,  1'b0);
        rem[0] = 0;
        #1;
        tick();
        chk("stall_drained", exp_a.size(), 0);
        do_reset();

        // Early release by requester 2; pointer moves to 3.
        set_prod(2, 8'h40, 1);
        push_a(2, 8'h40);
        #1;
        tick();
        chk("early_grant", grant_a, 4'b0100);
        tick();
        chk("early_still_busy", busy_a, 1'b1);
        set_prod(0, 8'h00, 5);
        set_prod(3, 8'h60, 5);
        #1;
        tick();
        chk("early_idle_busy",  busy_a,  1'b0);
        chk("early_idle_grant", grant_a, 4'b0000);
        tick();
        chk("early_next_grant", grant_a, 4'b1000);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        #1;
        tick();
        chk("early_drained", exp_a.size(), 0);
        do_reset();

        // BURST=1 instance: grants alternate word by word with idle gaps.
        push_b(0, 8'hA0);
        push_b(1, 8'hB1);
        push_b(0, 8'hA0);
        push_b(1, 8'hB1);
        valid_b = 4'b0011;
        #1;
        tick();
        for (int c = 0; c < 8; c++) begin
            chk("b1_grant", grant_b, B_SEQ[31-4*c -: 4]);
            if (c == 7) begin
                valid_b = '0;
                #1;
            end
            tick();
        end
        chk("b1_drained", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
